// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB bus arbiter.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BURST  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_e;

    // Number of beats in a burst; undefined-length bursts count as one so they never block.
    function automatic logic [4:0] burst_len(hburst_e b);
        case (b)
            HBURST_WRAP4, HBURST_INCR4:   burst_len = 5'd4;
            HBURST_WRAP8, HBURST_INCR8:   burst_len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
            default:                      burst_len = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module ahb_rr_picker #(
    parameter int unsigned NUM_MASTERS     = 2,
    parameter int unsigned NUM_MASTER_BITS = 1
) (
    input  logic [NUM_MASTERS-1:0]     req,
    input  logic [NUM_MASTER_BITS-1:0] last,
    output logic [NUM_MASTERS-1:0]     grant,
    output logic [NUM_MASTER_BITS-1:0] idx,
    output logic                       valid
);

    // Walk candidates last+1 .. last+NUM_MASTERS, taking the first one requesting.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
                if (!valid && req[j] && (j == (32'(last) + i) % NUM_MASTERS)) begin
                    valid    = 1'b1;
                    idx      = NUM_MASTER_BITS'(j);
                    grant[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with fixed-burst and locked-sequence protection.
module ahb_bus_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS     = 2,
    parameter int unsigned NUM_MASTER_BITS = 1,
    parameter int unsigned DEFAULT_MASTER  = 0
) (
    input  logic                       hclk,
    input  logic                       hreset,
    input  logic [NUM_MASTERS-1:0]     hbusreq,
    input  logic [NUM_MASTERS-1:0]     hlock,
    input  logic [1:0]                 htrans,
    input  logic [2:0]                 hburst,
    input  logic                       hready,
    output logic [NUM_MASTERS-1:0]     hgrant,
    output logic [NUM_MASTER_BITS-1:0] hmaster,
    output logic [NUM_MASTER_BITS-1:0] hmaster_data,
    output logic                       hmastlock
);

    localparam logic [NUM_MASTERS-1:0]     DefaultGrant = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [NUM_MASTER_BITS-1:0] DefaultIdx   = NUM_MASTER_BITS'(DEFAULT_MASTER);

    arb_state_e                 state_q, state_d;
    logic [3:0]                 beats_q, beats_d;
    logic [NUM_MASTER_BITS-1:0] rr_last_q;
    logic [NUM_MASTERS-1:0]     hgrant_q, grant_d;
    logic [NUM_MASTER_BITS-1:0] hmaster_q, hmaster_data_q;
    logic                       hmastlock_q;

    logic [NUM_MASTER_BITS-1:0] grant_idx;
    logic                       owner_lock;
    logic                       rearb;
    logic [NUM_MASTERS-1:0]     pick_grant;
    logic [NUM_MASTER_BITS-1:0] pick_idx;
    logic                       pick_valid;

    ahb_rr_picker #(
        .NUM_MASTERS     (NUM_MASTERS),
        .NUM_MASTER_BITS (NUM_MASTER_BITS)
    ) u_picker (
        .req   (hbusreq),
        .last  (rr_last_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Decode the granted index and the lock request of the address-phase owner.
    always_comb begin
        grant_idx  = '0;
        owner_lock = 1'b0;
        for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
            if (hgrant_q[j]) grant_idx = NUM_MASTER_BITS'(j);
            if (hmaster_q == NUM_MASTER_BITS'(j) && hlock[j]) owner_lock = 1'b1;
        end
    end

    // Burst beat counter, state and re-arbitration decision.
    always_comb begin
        beats_d = beats_q;
        if (hready && htrans == HTRANS_NONSEQ) begin
            beats_d = 4'(burst_len(hburst_e'(hburst)) - 5'd1);
        end else if (hready && htrans == HTRANS_SEQ && beats_q != 4'd0) begin
            beats_d = beats_q - 4'd1;
        end

        state_d = state_q;
        if (hready) begin
            if (owner_lock)            state_d = ARB_LOCKED;
            else if (beats_d != 4'd0)  state_d = ARB_BURST;
            else                       state_d = ARB_IDLE;
        end

        rearb   = hready && (state_d == ARB_IDLE);
        grant_d = pick_valid ? pick_grant : DefaultGrant;
    end

    // All arbiter state; the owner pipeline and grant only move on hready.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q        <= ARB_IDLE;
            beats_q        <= 4'd0;
            rr_last_q      <= DefaultIdx;
            hgrant_q       <= DefaultGrant;
            hmaster_q      <= DefaultIdx;
            hmaster_data_q <= DefaultIdx;
            hmastlock_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            if (hready) begin
                hmaster_q      <= grant_idx;
                hmaster_data_q <= hmaster_q;
                hmastlock_q    <= |(hlock & hgrant_q);
            end
            if (rearb) begin
                hgrant_q <= grant_d;
                // Parking on the default master does not advance the rotation.
                if (pick_valid) rr_last_q <= pick_idx;
            end
        end
    end

    assign hgrant       = hgrant_q;
    assign hmaster      = hmaster_q;
    assign hmaster_data = hmaster_data_q;
    assign hmastlock    = hmastlock_q;

endmodule
